// File: rtl/reg_bank_write_arbiter_pkg.sv
// reg_bank_write_arbiter_pkg: shared FSM encoding and packed-slice helper
package reg_bank_write_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting at ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin : pick
        logic [IDX_W-1:0] j;
        j   = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = IDX_W'((int'(ptr) + i) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter: round-robin write sequencer driving a register bank
module reg_bank_write_arbiter
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 4,
    parameter int N_REG  = 16,
    parameter int DATA_W = 21
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cke_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic                      clr_i,
    output logic [N_REG-1:0]          reg_en_o,
    output logic [DATA_W-1:0]         reg_data_o,
    output logic                      reg_rst_o,
    output logic                      err_o,
    output logic [$clog2(N_REQ)-1:0]  grant_id_o
);
    localparam int IDX_W = $clog2(N_REQ);
    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, win_idx;
    logic [N_REQ-1:0]   win_gnt;
    logic               win_any, accept, in_range;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req(req_valid_i),
        .ptr(ptr),
        .gnt(win_gnt),
        .idx(win_idx),
        .any(win_any)
    );

    assign req_ready_o = (cke_i && !clr_i && !rst_i && win_any) ? win_gnt : '0;
    assign accept      = |req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_id_o <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (cke_i) begin
            state <= state_nx;
            if (accept) begin
                ptr        <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                grant_id_o <= win_idx;
                addr_q     <= req_addr_i[slice_lo(int'(win_idx), ADDR_W) +: ADDR_W];
                data_q     <= req_data_i[slice_lo(int'(win_idx), DATA_W) +: DATA_W];
            end
        end
    end

    always_comb state_nx = clr_i ? CLEAR : accept ? WRITE : IDLE;

    always_comb begin
        in_range   = int'(addr_q) < N_REG;
        reg_en_o   = (state == WRITE && in_range) ? (N_REG'(1) << addr_q) : '0;
        err_o      = state == WRITE && !in_range;
        reg_rst_o  = state == CLEAR;
        reg_data_o = data_q;
    end
endmodule
